mem_wb_stage_skid: RTL

- Parametrised successor to the fixed-width MEM/WB pipeline register.
- Adds a valid/ready elastic handshake with a 2-entry skid buffer, which gives full throughput without a combinational ready path.
- Adds a synchronous flush, in-stage writeback-data selection (MemToReg mux) and a saturating back-pressure counter.
- Sits between the MEM stage/data memory and the register-file write port. Stall is now expressed as back-pressure (out_ready_i low), not a separate hold pin.

---
 rtl/mem_wb_stage_skid.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_wb_stage_skid.sv
// MEM/WB pipeline stage with a valid/ready handshake and a two-entry skid buffer.
// Also handles flush, selects the writeback data, and counts back-pressure cycles.
//
// state | meaning
// EMPTY | head and skid both empty
// BUSY  | head holds an entry, skid empty
// FULL  | head and skid both hold entries, upstream is stalled
module mem_wb_stage_skid #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [XLEN-1:0]  rd_data_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic [RA_W-1:0]  rd_addr_i,
  input  logic             reg_write_i,
  input  logic             mem_to_reg_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  alu_result_o,
  output logic [XLEN-1:0]  rd_data_o,
  output logic [XLEN-1:0]  mem_rdata_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic [RA_W-1:0]  rd_addr_o,
  output logic             reg_write_o,
  output logic             mem_to_reg_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd3
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rd;
    logic [XLEN-1:0] mem;
    logic [RA_W-1:0] addr;
    logic            reg_write;
    logic            mem_to_reg;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           h_q, h_d, s_q, s_d;
  entry_t           in_e;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             h_valid, s_valid, accept, pop;

  assign h_valid    = (state_q != ST_EMPTY);
  assign s_valid    = (state_q == ST_FULL);
  assign in_ready_o = ~s_valid;
  // A flushed cycle never takes the offered entry.
  assign accept     = in_valid_i & in_ready_o & ~flush_i;
  assign pop        = h_valid & out_ready_i;

  assign in_e = '{alu: alu_result_i, rd: rd_data_i, mem: mem_rdata_i,
                  addr: rd_addr_i, reg_write: reg_write_i, mem_to_reg: mem_to_reg_i};

  // Next-state and payload steering for the head/skid pair.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            h_d     = in_e;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && pop) begin
            h_d = in_e;
          end else if (accept) begin
            s_d     = in_e;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            h_d     = s_q;
            state_d = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where the head is valid but not taken.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (h_valid && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // State, payload and counter registers; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      h_q         <= '0;
      s_q         <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      s_q         <= s_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid_o  = h_valid;
  assign alu_result_o = h_q.alu;
  assign rd_data_o    = h_q.rd;
  assign mem_rdata_o  = h_q.mem;
  assign rd_addr_o    = h_q.addr;
  assign mem_to_reg_o = h_q.mem_to_reg;
  assign reg_write_o  = h_q.reg_write & h_valid;
  assign wb_data_o    = h_q.mem_to_reg ? h_q.mem : h_q.alu;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
